// File: rtl/match_reporter_pkg.sv
`default_nettype none
// ============================================================================
// match_reporter_pkg : shared defaults and helpers for the match reporter
// Revision 1.0 - initial release
// ============================================================================
package match_reporter_pkg;

  localparam int DEFAULT_DEPTH        = 16;
  localparam int DEFAULT_OFFSET_WIDTH = 32;
  localparam int DEFAULT_COUNT_WIDTH  = 32;

  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Holds at all-ones of the given width instead of wrapping; width <= 64.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int width);
    logic [63:0] max_v;
    max_v = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (v >= max_v) ? v : v + 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/match_reporter_if.sv
`default_nettype none
// ============================================================================
// match_reporter_if : character/result input and report valid/ready channel
// Revision 1.0 - initial release
// ============================================================================
interface match_reporter_if
  import match_reporter_pkg::*;
#(
  parameter int OFFSET_WIDTH = DEFAULT_OFFSET_WIDTH
) ();

  logic                    charValid;
  logic                    result;
  logic                    reportReady;
  logic                    reportValid;
  logic [OFFSET_WIDTH-1:0] reportOffset;

  modport master (
    output charValid, result, reportReady,
    input  reportValid, reportOffset
  );

  modport slave (
    input  charValid, result, reportReady,
    output reportValid, reportOffset
  );

endinterface
`default_nettype wire

// File: rtl/match_reporter_report_fifo.sv
`default_nettype none
// ============================================================================
// report_fifo : generic synchronous circular-buffer FIFO, no bypass path
// Revision 1.0 - initial release
// ============================================================================
module report_fifo
  import match_reporter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_OFFSET_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [log2(DEPTH):0]   count_o
);

  localparam int PW = log2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/match_reporter.sv
`default_nettype none
// ============================================================================
// match_reporter : queues stream offsets of automaton matches, keeps totals
// Revision 1.0 - initial release
// ============================================================================
module match_reporter
  import match_reporter_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int OFFSET_WIDTH = DEFAULT_OFFSET_WIDTH,
  parameter int COUNT_WIDTH  = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  match_reporter_if.slave        bus,
  output logic [COUNT_WIDTH-1:0] matchCount,
  output logic [COUNT_WIDTH-1:0] dropCount,
  output logic                   overflow
);

  logic [OFFSET_WIDTH-1:0] offs_q, offs_d;
  logic [COUNT_WIDTH-1:0]  matchCount_q, matchCount_d;
  logic [COUNT_WIDTH-1:0]  dropCount_q, dropCount_d;
  logic                    overflow_q, overflow_d;

  logic                    w_hit;
  logic                    w_pop;
  logic                    w_drop;
  logic                    w_full;
  logic                    w_empty;
  logic [log2(DEPTH):0]    w_count_unused;

  assign w_hit  = bus.charValid && bus.result;
  assign w_pop  = !w_empty && bus.reportReady;
  assign w_drop = w_hit && w_full && !w_pop;

  always_comb begin
    offs_d       = offs_q;
    matchCount_d = matchCount_q;
    dropCount_d  = dropCount_q;
    overflow_d   = overflow_q;
    if (bus.charValid) offs_d = offs_q + OFFSET_WIDTH'(1);
    if (w_hit)  matchCount_d = COUNT_WIDTH'(sat_inc(64'(matchCount_q), COUNT_WIDTH));
    if (w_drop) begin
      dropCount_d = COUNT_WIDTH'(sat_inc(64'(dropCount_q), COUNT_WIDTH));
      overflow_d  = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      offs_q       <= '0;
      matchCount_q <= '0;
      dropCount_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      offs_q       <= offs_d;
      matchCount_q <= matchCount_d;
      dropCount_q  <= dropCount_d;
      overflow_q   <= overflow_d;
    end
  end

  // The recorded offset is the pre-increment value: the matching character's index.
  report_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OFFSET_WIDTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (w_hit),
    .data_i  (offs_q),
    .pop_i   (bus.reportReady),
    .data_o  (bus.reportOffset),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count_unused)
  );

  assign bus.reportValid = !w_empty;
  assign matchCount      = matchCount_q;
  assign dropCount       = dropCount_q;
  assign overflow        = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_match_reporter.sv
`default_nettype none
// ============================================================================
// tb_match_reporter : directed self-checking bench for match_reporter
// Revision 1.0 - initial release
// ============================================================================
module tb_match_reporter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  match_reporter_if #(.OFFSET_WIDTH(32)) bus ();
  logic [31:0] matchCount, dropCount;
  logic        overflow;

  match_reporter #(.DEPTH(16), .OFFSET_WIDTH(32), .COUNT_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave),
    .matchCount(matchCount), .dropCount(dropCount), .overflow(overflow)
  );

  // Narrow build: 4-bit offsets wrap quickly, 3-bit counters saturate quickly.
  match_reporter_if #(.OFFSET_WIDTH(4)) sbus ();
  logic [2:0] s_matchCount, s_dropCount;
  logic       s_overflow;

  match_reporter #(.DEPTH(4), .OFFSET_WIDTH(4), .COUNT_WIDTH(3)) sdut (
    .clock(clock), .reset(reset), .bus(sbus.slave),
    .matchCount(s_matchCount), .dropCount(s_dropCount), .overflow(s_overflow)
  );

  int tests = 0;
  int fails = 0;
  int am    = 0;
  logic [31:0] got[$];
  logic [3:0]  sgot[$];

  always @(negedge clock) begin
    if (!reset && bus.reportValid && bus.reportReady)   got.push_back(bus.reportOffset);
    if (!reset && sbus.reportValid && sbus.reportReady) sgot.push_back(sbus.reportOffset);
  end

  // Golden "ROMEO" automaton with a self-loop on the final O.
  function automatic logic am_step(input byte ch);
    int nxt;
    if (ch == "R")                              nxt = 1;
    else if (am == 1 && ch == "O")              nxt = 2;
    else if (am == 2 && ch == "M")              nxt = 3;
    else if (am == 3 && ch == "E")              nxt = 4;
    else if ((am == 4 || am == 5) && ch == "O") nxt = 5;
    else                                        nxt = 0;
    am = nxt;
    return (nxt == 5);
  endfunction

  task automatic cyc(input logic cv, input logic res, input logic rdy);
    bus.charValid = cv; bus.result = res; bus.reportReady = rdy;
    @(posedge clock); #1;
  endtask

  task automatic scyc(input logic cv, input logic res, input logic rdy);
    sbus.charValid = cv; sbus.result = res; sbus.reportReady = rdy;
    @(posedge clock); #1;
  endtask

  task automatic feed(input string s, input logic rdy);
    for (int i = 0; i < s.len(); i++) cyc(1'b1, am_step(s[i]), rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sbus.charValid = 1'b0; sbus.result = 1'b0; sbus.reportReady = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    am = 0;
    got.delete();
    sgot.delete();
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (!bus.reportValid) break;
      cyc(1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus.reportValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.reportValid); end
    tests++; if (bus.reportOffset !== 32'd0) begin fails++; $display("FAIL reset_offset: got %0d want 0", bus.reportOffset); end
    tests++; if (matchCount !== 32'd0) begin fails++; $display("FAIL reset_match: got %0d want 0", matchCount); end
    tests++; if (dropCount !== 32'd0) begin fails++; $display("FAIL reset_drop: got %0d want 0", dropCount); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    tests++; if (sbus.reportValid !== 1'b0) begin fails++; $display("FAIL reset_small_valid: got %b want 0", sbus.reportValid); end
  endtask

  task automatic test_romeo();
    do_reset();
    feed("xROME", 1'b1);
    cyc(1'b1, am_step("O"), 1'b1);
    tests++; if (bus.reportValid !== 1'b1) begin fails++; $display("FAIL romeo_latency: valid %b want 1", bus.reportValid); end
    tests++; if (bus.reportOffset !== 32'd5) begin fails++; $display("FAIL romeo_head: got %0d want 5", bus.reportOffset); end
    feed("x", 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    tests++; if (got.size() != 1) begin fails++; $display("FAIL romeo_count: got %0d reports want 1", got.size()); end
    else begin tests++; if (got[0] !== 32'd5) begin fails++; $display("FAIL romeo_offset: got %0d want 5", got[0]); end end
    tests++; if (matchCount !== 32'd1) begin fails++; $display("FAIL romeo_match: got %0d want 1", matchCount); end
    tests++; if (dropCount !== 32'd0) begin fails++; $display("FAIL romeo_drop: got %0d want 0", dropCount); end
  endtask

  task automatic test_gap();
    do_reset();
    feed("xRO", 1'b1);
    repeat (3) cyc(1'b0, 1'b1, 1'b1);  // result asserted while invalid must be ignored
    feed("MEO", 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    tests++; if (got.size() != 1) begin fails++; $display("FAIL gap_count: got %0d reports want 1", got.size()); end
    else begin tests++; if (got[0] !== 32'd5) begin fails++; $display("FAIL gap_offset: got %0d want 5", got[0]); end end
    tests++; if (matchCount !== 32'd1) begin fails++; $display("FAIL gap_match: got %0d want 1", matchCount); end
  endtask

  task automatic test_overflow();
    string s;
    s = "ROMEO";
    for (int k = 0; k < 18; k++) s = {s, "O"};
    do_reset();
    feed(s, 1'b0);
    tests++; if (bus.reportOffset !== 32'd4) begin fails++; $display("FAIL ovf_head: got %0d want 4", bus.reportOffset); end
    tests++; if (matchCount !== 32'd19) begin fails++; $display("FAIL ovf_match: got %0d want 19", matchCount); end
    tests++; if (dropCount !== 32'd3) begin fails++; $display("FAIL ovf_drop: got %0d want 3", dropCount); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    drain(40);
    tests++; if (bus.reportValid !== 1'b0) begin fails++; $display("FAIL ovf_drain_timeout: valid %b want 0", bus.reportValid); end
    tests++; if (got.size() != 16) begin fails++; $display("FAIL ovf_drain_count: got %0d want 16", got.size()); end
    else for (int i = 0; i < 16; i++) begin
      tests++; if (got[i] !== 32'(4 + i)) begin fails++; $display("FAIL ovf_order[%0d]: got %0d want %0d", i, got[i], 4 + i); end
    end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_full_pop();
    string s;
    s = "ROMEO";
    for (int k = 0; k < 15; k++) s = {s, "O"};
    do_reset();
    feed(s, 1'b0);
    cyc(1'b1, am_step("O"), 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    tests++; if (dropCount !== 32'd0) begin fails++; $display("FAIL fullpop_drop: got %0d want 0", dropCount); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fullpop_ovf: got %b want 0", overflow); end
    tests++; if (matchCount !== 32'd17) begin fails++; $display("FAIL fullpop_match: got %0d want 17", matchCount); end
    tests++; if (bus.reportOffset !== 32'd5) begin fails++; $display("FAIL fullpop_head: got %0d want 5", bus.reportOffset); end
    drain(40);
    tests++; if (got.size() != 17) begin fails++; $display("FAIL fullpop_count: got %0d want 17", got.size()); end
    else for (int i = 0; i < 17; i++) begin
      tests++; if (got[i] !== 32'(4 + i)) begin fails++; $display("FAIL fullpop_order[%0d]: got %0d want %0d", i, got[i], 4 + i); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    feed("ROMEOOOOOO", 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    tests++; if (bus.reportValid !== 1'b0) begin fails++; $display("FAIL b2b_throughput: valid %b want 0", bus.reportValid); end
    tests++; if (got.size() != 6) begin fails++; $display("FAIL b2b_count: got %0d want 6", got.size()); end
    else for (int i = 0; i < 6; i++) begin
      tests++; if (got[i] !== 32'(4 + i)) begin fails++; $display("FAIL b2b_order[%0d]: got %0d want %0d", i, got[i], 4 + i); end
    end
    tests++; if (matchCount !== 32'd6) begin fails++; $display("FAIL b2b_match: got %0d want 6", matchCount); end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_w [3];
    exp_w[0] = 4'd15; exp_w[1] = 4'd0; exp_w[2] = 4'd1;
    do_reset();
    for (int i = 0; i < 18; i++) scyc(1'b1, (i >= 15), 1'b1);
    scyc(1'b0, 1'b0, 1'b1);
    scyc(1'b0, 1'b0, 1'b1);
    tests++; if (sgot.size() != 3) begin fails++; $display("FAIL wrap_count: got %0d want 3", sgot.size()); end
    else for (int i = 0; i < 3; i++) begin
      tests++; if (sgot[i] !== exp_w[i]) begin fails++; $display("FAIL wrap_offset[%0d]: got %0d want %0d", i, sgot[i], exp_w[i]); end
    end
    tests++; if (s_overflow !== 1'b0) begin fails++; $display("FAIL wrap_ovf: got %b want 0", s_overflow); end
    tests++; if (s_matchCount !== 3'd3) begin fails++; $display("FAIL wrap_match: got %0d want 3", s_matchCount); end
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (12) scyc(1'b1, 1'b1, 1'b0);
    tests++; if (s_matchCount !== 3'd7) begin fails++; $display("FAIL sat_match: got %0d want 7", s_matchCount); end
    tests++; if (s_dropCount !== 3'd7) begin fails++; $display("FAIL sat_drop: got %0d want 7", s_dropCount); end
    tests++; if (s_overflow !== 1'b1) begin fails++; $display("FAIL sat_ovf: got %b want 1", s_overflow); end
    for (int i = 0; i < 8; i++) begin
      if (!sbus.reportValid) break;
      scyc(1'b0, 1'b0, 1'b1);
    end
    tests++; if (sgot.size() != 4) begin fails++; $display("FAIL sat_drain_count: got %0d want 4", sgot.size()); end
    else for (int i = 0; i < 4; i++) begin
      tests++; if (sgot[i] !== 4'(i)) begin fails++; $display("FAIL sat_order[%0d]: got %0d want %0d", i, sgot[i], i); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    feed("ROMEOOOOO", 1'b0);
    tests++; if (matchCount !== 32'd5) begin fails++; $display("FAIL rmid_pre_match: got %0d want 5", matchCount); end
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    am = 0;
    tests++; if (bus.reportValid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b want 0", bus.reportValid); end
    tests++; if (bus.reportOffset !== 32'd0) begin fails++; $display("FAIL rmid_offset: got %0d want 0", bus.reportOffset); end
    tests++; if (matchCount !== 32'd0) begin fails++; $display("FAIL rmid_match: got %0d want 0", matchCount); end
    tests++; if (dropCount !== 32'd0) begin fails++; $display("FAIL rmid_drop: got %0d want 0", dropCount); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rmid_ovf: got %b want 0", overflow); end
    cyc(1'b1, 1'b1, 1'b0);
    tests++; if (bus.reportValid !== 1'b1) begin fails++; $display("FAIL rmid_next_valid: got %b want 1", bus.reportValid); end
    tests++; if (bus.reportOffset !== 32'd0) begin fails++; $display("FAIL rmid_next_offset: got %0d want 0", bus.reportOffset); end
    tests++; if (matchCount !== 32'd1) begin fails++; $display("FAIL rmid_next_match: got %0d want 1", matchCount); end
    drain(4);
  endtask

  initial begin
    bus.charValid = 1'b0; bus.result = 1'b0; bus.reportReady = 1'b0;
    sbus.charValid = 1'b0; sbus.result = 1'b0; sbus.reportReady = 1'b0;
    test_reset();
    test_romeo();
    test_gap();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_wrap();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
